gtp_frame_rx: RTL and testbench
===============================

# gtp_frame_rx

Per-lane frame receiver in the 125 MHz GTP domain, placed between one 16-bit GTP receive lane (data plus K-char flag) and that lane's receive FIFO. It delimits frames on the idle K-char stream and validates header, length and checksum. It forwards header and payload words, then appends one status trailer word per frame. It also keeps saturating frame and error counters that the register block reads.

## Interface
Parameters:
- MAXLEN, 1023: largest legal payload length in words. The header length field is 10 bits wide.
- TRL_TAG, 8'hFE: upper byte of the trailer word.

Ports:
- clk  in  1  125 MHz GTP recovered clock. This is the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  receive enable. Sampled only in IDLE.
- gtp_dat  in  16  received lane word.
- gtp_kchar  in  1  1 = gtp_dat is a K-character (idle or comma).
- fifo_afull  in  1  downstream FIFO has fewer than MAXLEN+3 free words.
- out_dat  out  16  word to the FIFO.
- out_vld  out  1  FIFO write strobe.
- out_sof  out  1  out_dat is a header word.
- out_eof  out  1  out_dat is a trailer word.
- frame_cnt  out  16  good frames received. Saturates at 16'hFFFF.
- err_cnt  out  16  erroneous or dropped frames plus stray words. Saturates.
- busy  out  1  state is not IDLE.

## Operation
Frame format on the lane:
- Any number of K-words, then a header, then L payload words, then a checksum word, then a K-word.
- Header: kchar=0 and bit15=1. Bits [14:10] are the channel id. Bits [9:0] are L, with 1 ≤ L ≤ MAXLEN.
- Checksum: the 16-bit sum, mod 2^16, of the header and all payload words.

States:
- IDLE:
  - K-word: stay.
  - Non-K word with bit15=0: err_cnt+1, stay. This is a stray word.
  - Header with L=0, or en=0: err_cnt+1 (for L=0 only), go to SKIP.
  - Header with fifo_afull=1: err_cnt+1, go to SKIP. The whole frame is dropped and nothing is written.
  - Valid header: write the header with out_sof, set sum=header, load cnt=L, go to PAY.
- PAY:
  - Non-K word: write it, sum+=word, cnt-1. When cnt reaches 0, go to CSUM.
  - K-word: truncation. Write a trailer with TRUNC set, err_cnt+1, go to IDLE.
- CSUM:
  - Non-K word: compare it with sum. Write a trailer with CSERR=(word≠sum). If match, frame_cnt+1; else err_cnt+1. Go to IDLE.
  - K-word: truncation, handled as in PAY.
- SKIP: discard words until a K-word, then go to IDLE.
- Trailer word: {TRL_TAG, 4'h0, CHAN[4:1]... }. Precisely, bits [15:8]=TRL_TAG, [7:3]=channel id, [2]=0, [1]=TRUNC, [0]=CSERR.
- A frame only reaches PAY if fifo_afull was low at its header. The block never sees out_vld asserted into a full FIFO during a frame.
- A non-K word with bit15=1 that arrives after the CSUM word, without an intervening K-word, is treated as a stray word by IDLE rules. Stray words are counted one by one.
- en=0 mid-frame does not abort the frame. The frame completes normally.

## Timing
- Reset values: out_dat=0, out_vld=0, out_sof=0, out_eof=0, frame_cnt=0, err_cnt=0, busy=0, state=IDLE.
- All outputs are registered. Latency is 1 clk: an input word at edge n appears on out_* at edge n+1.
- The trailer appears 1 clk after the checksum word, or 1 clk after the truncating K-word.
- Exactly one out_vld per forwarded word. There are no gaps inserted.
- out_sof and out_eof are each asserted only together with out_vld.
- Counters update on the same edge as the corresponding trailer or drop decision.
- At 16'hFFFF a counter holds its value. It never wraps.
- Asserting rst_n low mid-frame clears everything asynchronously. The partial frame left in the FIFO is the system's responsibility, and the block emits no trailer for it.
- Back-to-back frames are allowed with a single K-word between them. A header is accepted on the cycle right after the returning-to-IDLE K-word.

## Test plan
- Good frame: K, header 16'h8403 (ch 1, L=3), payload 1,2,3, checksum 16'h8409, K. Required: out words 8403(sof), 0001, 0002, 0003, FE08(eof); frame_cnt=1; err_cnt=0.
- Bad checksum: the same frame with checksum 16'h0000. Required: trailer FE09, err_cnt=1, frame_cnt=0.
- Truncation: header 16'h8005 (ch 0, L=5), payload 1,2, then K. Required: 8005, 0001, 0002, FE02; state returns to IDLE; err_cnt=1.
- fifo_afull=1 at header 16'h8002, with the rest of a valid frame following. Required: no out_vld for the whole frame, err_cnt=1. A following good frame sent with afull=0 is received normally.
- Stray words: three non-K words 16'h1234 in IDLE. Required: err_cnt=3, no output. A header with L=0 (16'h8000) followed by 2 words and K: err_cnt+1, no output, back to IDLE.
- Saturation and reset: force 65536+2 stray words; err_cnt stays at FFFF. Assert rst_n low in PAY; all outputs go to 0 immediately and busy=0.

Source files
------------

// File: rtl/gtp_frame_rx.sv
// gtp_frame_rx: per-lane frame receiver for one 16-bit GTP receive lane.
// Delimits frames on the K-char idle stream, checks header length and checksum,
// forwards header and payload to the lane FIFO and appends one status trailer.
module gtp_frame_rx #(
    parameter int unsigned MAXLEN  = 1023,
    parameter logic [7:0]  TRL_TAG = 8'hFE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] gtp_dat,
    input  logic        gtp_kchar,
    input  logic        fifo_afull,
    output logic [15:0] out_dat,
    output logic        out_vld,
    output logic        out_sof,
    output logic        out_eof,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAY,
        S_CSUM,
        S_SKIP
    } state_t;

    localparam logic [10:0] MAXLEN_W = 11'(MAXLEN);

    state_t      state, state_nxt;
    logic [9:0]  cnt, cnt_nxt;
    logic [15:0] sum, sum_nxt;
    logic [4:0]  chan, chan_nxt;
    logic [15:0] dat_nxt;
    logic        vld_nxt, sof_nxt, eof_nxt;
    logic        frm_inc, err_inc;
    logic [10:0] len_ext;
    logic        len_bad;
    logic        cs_err;

    assign len_ext = {1'b0, gtp_dat[9:0]};
    assign len_bad = (len_ext == '0) || (len_ext > MAXLEN_W);
    assign cs_err  = (gtp_dat != sum);
    assign busy    = (state != S_IDLE);

    // Next-state, datapath and output-strobe decode for the frame FSM
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sum_nxt   = sum;
        chan_nxt  = chan;
        dat_nxt   = out_dat;
        vld_nxt   = 1'b0;
        sof_nxt   = 1'b0;
        eof_nxt   = 1'b0;
        frm_inc   = 1'b0;
        err_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!gtp_kchar) begin
                    if (!gtp_dat[15]) begin
                        err_inc = 1'b1;
                    end else if (len_bad || !en) begin
                        err_inc   = len_bad;
                        state_nxt = S_SKIP;
                    end else if (fifo_afull) begin
                        err_inc   = 1'b1;
                        state_nxt = S_SKIP;
                    end else begin
                        vld_nxt   = 1'b1;
                        sof_nxt   = 1'b1;
                        dat_nxt   = gtp_dat;
                        sum_nxt   = gtp_dat;
                        cnt_nxt   = gtp_dat[9:0];
                        chan_nxt  = gtp_dat[14:10];
                        state_nxt = S_PAY;
                    end
                end
            end
            S_PAY, S_CSUM: begin
                vld_nxt = 1'b1;
                if (gtp_kchar) begin
                    eof_nxt   = 1'b1;
                    dat_nxt   = {TRL_TAG, chan, 3'b010};
                    err_inc   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (state == S_PAY) begin
                    dat_nxt = gtp_dat;
                    sum_nxt = sum + gtp_dat;
                    cnt_nxt = cnt - 10'd1;
                    if (cnt == 10'd1) begin
                        state_nxt = S_CSUM;
                    end
                end else begin
                    eof_nxt   = 1'b1;
                    dat_nxt   = {TRL_TAG, chan, 2'b00, cs_err};
                    err_inc   = cs_err;
                    frm_inc   = !cs_err;
                    state_nxt = S_IDLE;
                end
            end
            S_SKIP: begin
                if (gtp_kchar) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame state, running checksum, length counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sum     <= '0;
            chan    <= '0;
            out_dat <= '0;
            out_vld <= 1'b0;
            out_sof <= 1'b0;
            out_eof <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            sum     <= sum_nxt;
            chan    <= chan_nxt;
            out_dat <= dat_nxt;
            out_vld <= vld_nxt;
            out_sof <= sof_nxt;
            out_eof <= eof_nxt;
        end
    end

    // Saturating good-frame and error counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (frm_inc && (frame_cnt != '1)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (err_inc && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_gtp_frame_rx.sv
// tb_gtp_frame_rx: scoreboard bench for gtp_frame_rx. Expected FIFO words
// ({sof, eof, dat}) are queued as stimulus is driven and popped on out_vld.
module tb_gtp_frame_rx;

    localparam logic [15:0] KW = 16'h50BC;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] gtp_dat;
    logic        gtp_kchar;
    logic        fifo_afull;
    logic [15:0] out_dat;
    logic        out_vld;
    logic        out_sof;
    logic        out_eof;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
    logic        busy;

    logic [17:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_frm = '0;
    logic [15:0] exp_err = '0;

    gtp_frame_rx #(
        .MAXLEN (1023),
        .TRL_TAG(8'hFE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .gtp_dat   (gtp_dat),
        .gtp_kchar (gtp_kchar),
        .fifo_afull(fifo_afull),
        .out_dat   (out_dat),
        .out_vld   (out_vld),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic drive(input logic k, input logic [15:0] d);
        gtp_kchar = k;
        gtp_dat   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(exp_frm));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(exp_err));
    endtask

    // Generic frame: npay payload words; checksum only when npay == len, else truncated.
    task automatic tx_frame(input logic [4:0] ch, input logic [9:0] len, input int unsigned npay,
                            input logic corrupt, input logic afull, input logic en_drop);
        logic [15:0] hdr, w, s;
        logic        acc, en_saved;
        en_saved = en;
        hdr = {1'b1, ch, len};
        s   = hdr;
        acc = en && !afull && (len != 10'd0);
        if ((len == 10'd0) || (en && afull)) exp_err = sat(exp_err);
        fifo_afull = afull;
        if (acc) exp_q.push_back({2'b10, hdr});
        drive(1'b0, hdr);
        fifo_afull = 1'b0;
        for (int unsigned i = 0; i < npay; i++) begin
            w = 16'($urandom);
            if (en_drop) en = 1'b0;
            s = s + w;
            if (acc) exp_q.push_back({2'b00, w});
            drive(1'b0, w);
        end
        if (npay == 32'(len)) begin
            if (acc) begin
                exp_q.push_back({2'b01, 8'hFE, ch, 2'b00, corrupt});
                if (corrupt) exp_err = sat(exp_err);
                else         exp_frm = sat(exp_frm);
            end
            drive(1'b0, corrupt ? ~s : s);
        end else if (acc) begin
            exp_q.push_back({2'b01, 8'hFE, ch, 3'b010});
            exp_err = sat(exp_err);
        end
        drive(1'b1, KW);
        en = en_saved;
    endtask

    // Output monitor: every FIFO write must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && out_vld) begin
            chk("vld_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("out_word", {14'd0, out_sof, out_eof, out_dat}, {14'd0, exp_q.pop_front()});
        end
    end

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        fifo_afull = 1'b0;
        gtp_kchar  = 1'b1;
        gtp_dat    = KW;
        repeat (3) @(posedge clk);
        #2;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.out_vld", 32'(out_vld), 32'd0);
        chk("rst.out_dat", 32'(out_dat), 32'd0);
        rst_n = 1'b1;
        chk_cnts("rst");
        @(posedge clk);
        #1;

        // Good frame, literal expectations
        exp_q.push_back({2'b10, 16'h8403});
        exp_q.push_back({2'b00, 16'h0001});
        exp_q.push_back({2'b00, 16'h0002});
        exp_q.push_back({2'b00, 16'h0003});
        exp_q.push_back({2'b01, 16'hFE08});
        drive(1'b1, KW);
        drive(1'b0, 16'h8403);
        chk("good.busy", 32'(busy), 32'd1);
        drive(1'b0, 16'h0001);
        drive(1'b0, 16'h0002);
        drive(1'b0, 16'h0003);
        drive(1'b0, 16'h8409);
        drive(1'b1, KW);
        exp_frm = 16'd1;
        chk_cnts("good");

        // Same frame with a bad checksum
        exp_q.push_back({2'b10, 16'h8403});
        exp_q.push_back({2'b00, 16'h0001});
        exp_q.push_back({2'b00, 16'h0002});
        exp_q.push_back({2'b00, 16'h0003});
        exp_q.push_back({2'b01, 16'hFE09});
        drive(1'b0, 16'h8403);
        drive(1'b0, 16'h0001);
        drive(1'b0, 16'h0002);
        drive(1'b0, 16'h0003);
        drive(1'b0, 16'h0000);
        drive(1'b1, KW);
        exp_err = 16'd1;
        chk_cnts("badcs");

        // Truncated frame
        exp_q.push_back({2'b10, 16'h8005});
        exp_q.push_back({2'b00, 16'h0001});
        exp_q.push_back({2'b00, 16'h0002});
        exp_q.push_back({2'b01, 16'hFE02});
        drive(1'b0, 16'h8005);
        drive(1'b0, 16'h0001);
        drive(1'b0, 16'h0002);
        drive(1'b1, KW);
        exp_err = 16'd2;
        chk("trunc.busy", 32'(busy), 32'd0);
        chk_cnts("trunc");

        // Dropped on fifo_afull, then a normal frame right behind it
        tx_frame(5'd0, 10'd2, 2, 1'b0, 1'b1, 1'b0);
        chk_cnts("afull");
        tx_frame(5'd3, 10'd4, 4, 1'b0, 1'b0, 1'b0);
        chk_cnts("after_afull");

        // Stray words, then a zero-length header
        repeat (3) begin
            drive(1'b0, 16'h1234);
            exp_err = sat(exp_err);
        end
        chk_cnts("stray");
        tx_frame(5'd0, 10'd0, 2, 1'b0, 1'b0, 1'b0);
        chk("len0.busy", 32'(busy), 32'd0);
        chk_cnts("len0");

        // Back-to-back frames: random channels/lengths, some corrupt or truncated
        tx_frame(5'd31, 10'd1, 1, 1'b0, 1'b0, 1'b0);
        tx_frame(5'd17, 10'd40, 40, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [9:0] l;
            int unsigned np;
            l  = 10'($urandom_range(1, 12));
            np = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 32'(l) - 1)) : 32'(l);
            tx_frame(5'($urandom), l, np, 1'($urandom), 1'b0, 1'b0);
        end
        chk_cnts("random");

        // en low at a header drops silently; en low mid-frame does not abort
        en = 1'b0;
        tx_frame(5'd2, 10'd3, 3, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        chk_cnts("en_off");
        tx_frame(5'd9, 10'd5, 5, 1'b0, 1'b0, 1'b1);
        chk_cnts("en_mid");

        // Error counter saturation
        for (int i = 0; i < 65538; i++) begin
            drive(1'b0, 16'h1234);
            exp_err = sat(exp_err);
        end
        drive(1'b1, KW);
        chk("sat.err_cnt", 32'(err_cnt), 32'h0000FFFF);
        chk_cnts("sat");

        // Asynchronous reset in the middle of a payload
        exp_q.push_back({2'b10, 16'h8405});
        exp_q.push_back({2'b00, 16'h0011});
        drive(1'b0, 16'h8405);
        drive(1'b0, 16'h0011);
        @(negedge clk);
        #2;
        chk("pay.busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst.out", {13'd0, out_vld, out_sof, out_eof, out_dat}, 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        exp_frm = '0;
        exp_err = '0;
        chk_cnts("arst");
        gtp_kchar = 1'b1;
        gtp_dat   = KW;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tx_frame(5'd4, 10'd2, 2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, KW);
        drive(1'b1, KW);
        chk_cnts("recover");
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
